// File: rtl/wasm_value_stack.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// wasm_value_stack
//   Operand/value stack for the WebAssembly CPU. Holds operands between
//   execute cycles and presents the top two entries combinationally to the ALU.
//   Single-cycle PUSH, POP, REPLACE, BINOP, DUP, SWAP and CLEAR. Precondition
//   violations raise a sticky trap code that freezes the stack until reset.
//
// Parameters
//   DW     entry width in bits
//   DEPTH  log2 of the number of entries (2**DEPTH entries)
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   valid    in   op strobe; stack holds when low
//   op       in   3-bit op code (0 NOP,1 PUSH,2 POP,3 REPLACE,4 BINOP,5 DUP,
//                 6 SWAP,7 CLEAR)
//   data_in  in   value for PUSH / REPLACE / BINOP
//   top      out  entry at count-1, 0 when empty
//   next     out  entry at count-2, 0 when fewer than two entries
//   empty    out  count == 0
//   full     out  count == 2**DEPTH
//   count    out  number of entries (DEPTH+1 bits)
//   trap     out  0 none, 1 overflow, 2 underflow; sticky until reset
// -----------------------------------------------------------------------------
module wasm_value_stack #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [2:0]       op,
  input  logic [DW-1:0]    data_in,
  output logic [DW-1:0]    top,
  output logic [DW-1:0]    next,
  output logic             empty,
  output logic             full,
  output logic [DEPTH:0]   count,
  output logic [3:0]       trap
);

  localparam int               ENTRIES = 1 << DEPTH;
  localparam logic [DEPTH:0]   CAP     = (DEPTH+1)'(ENTRIES);
  localparam logic [DEPTH:0]   C_ONE   = (DEPTH+1)'(1);
  localparam logic [DEPTH:0]   C_TWO   = (DEPTH+1)'(2);
  localparam logic [DEPTH-1:0] A_ONE   = DEPTH'(1);
  localparam logic [DEPTH-1:0] A_TWO   = DEPTH'(2);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_REPLACE = 3'd3;
  localparam logic [2:0] OP_BINOP   = 3'd4;
  localparam logic [2:0] OP_DUP     = 3'd5;
  localparam logic [2:0] OP_SWAP    = 3'd6;
  localparam logic [2:0] OP_CLEAR   = 3'd7;

  localparam logic [3:0] TRAP_NONE = 4'd0;
  localparam logic [3:0] TRAP_OVF  = 4'd1;
  localparam logic [3:0] TRAP_UNF  = 4'd2;

  logic [DW-1:0]    r_mem [ENTRIES];
  logic [DEPTH:0]   r_count;
  logic [3:0]       r_trap;

  logic [DEPTH-1:0] w_a0;        // slot above the top (push target)
  logic [DEPTH-1:0] w_a1;        // top slot
  logic [DEPTH-1:0] w_a2;        // second slot
  logic             w_has1;
  logic             w_has2;
  logic             w_room;
  logic [DW-1:0]    w_top_raw;
  logic [DW-1:0]    w_next_raw;
  logic             w_active;
  logic             w_ovf;
  logic             w_unf;
  logic             w_we;
  logic [DEPTH-1:0] w_waddr;
  logic [DW-1:0]    w_wdata;
  logic             w_swap;
  logic [DEPTH:0]   w_count_next;

  // Slot addresses wrap modulo 2**DEPTH; when count==CAP the low bits are 0
  // and count-1 correctly lands on the last slot.
  assign w_a0 = r_count[DEPTH-1:0];
  assign w_a1 = r_count[DEPTH-1:0] - A_ONE;
  assign w_a2 = r_count[DEPTH-1:0] - A_TWO;

  assign w_has1 = (r_count != '0);
  assign w_has2 = (r_count >= C_TWO);
  assign w_room = (r_count != CAP);

  assign w_top_raw  = r_mem[w_a1];
  assign w_next_raw = r_mem[w_a2];

  // Once a trap is latched the stack is frozen until reset.
  assign w_active = valid && (r_trap == TRAP_NONE);

  always_comb begin
    w_ovf        = 1'b0;
    w_unf        = 1'b0;
    w_we         = 1'b0;
    w_waddr      = w_a0;
    w_wdata      = data_in;
    w_swap       = 1'b0;
    w_count_next = r_count;
    case (op)
      OP_NOP: begin
      end
      OP_PUSH: begin
        if (!w_room) begin
          w_ovf = 1'b1;
        end else begin
          w_we         = 1'b1;
          w_waddr      = w_a0;
          w_count_next = r_count + C_ONE;
        end
      end
      OP_POP: begin
        if (!w_has1) w_unf = 1'b1;
        else         w_count_next = r_count - C_ONE;
      end
      OP_REPLACE: begin
        if (!w_has1) begin
          w_unf = 1'b1;
        end else begin
          w_we    = 1'b1;
          w_waddr = w_a1;
        end
      end
      OP_BINOP: begin
        // The ALU result overwrites the second entry and the top is dropped.
        if (!w_has2) begin
          w_unf = 1'b1;
        end else begin
          w_we         = 1'b1;
          w_waddr      = w_a2;
          w_count_next = r_count - C_ONE;
        end
      end
      OP_DUP: begin
        if (!w_has1) begin
          w_unf = 1'b1;
        end else if (!w_room) begin
          w_ovf = 1'b1;
        end else begin
          w_we         = 1'b1;
          w_waddr      = w_a0;
          w_wdata      = w_top_raw;
          w_count_next = r_count + C_ONE;
        end
      end
      OP_SWAP: begin
        // Main write port moves next into the top slot; the dedicated swap
        // path moves top into the second slot on the same edge.
        if (!w_has2) begin
          w_unf = 1'b1;
        end else begin
          w_we    = 1'b1;
          w_waddr = w_a1;
          w_wdata = w_next_raw;
          w_swap  = 1'b1;
        end
      end
      OP_CLEAR: begin
        w_count_next = '0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_trap  <= TRAP_NONE;
    end else if (w_active) begin
      if (w_ovf)      r_trap  <= TRAP_OVF;
      else if (w_unf) r_trap  <= TRAP_UNF;
      else            r_count <= w_count_next;
    end
  end

  // Storage has no reset; gating with reset keeps an op that coincides with
  // reset from touching it.
  always_ff @(posedge clk) begin
    if (reset && w_active && w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
    if (reset && w_active && w_swap) begin
      r_mem[w_a2] <= w_top_raw;
    end
  end

  // Never expose stale storage below the live entries.
  assign top   = w_has1 ? w_top_raw  : '0;
  assign next  = w_has2 ? w_next_raw : '0;
  assign empty = (r_count == '0);
  assign full  = (r_count == CAP);
  assign count = r_count;
  assign trap  = r_trap;

endmodule

// File: tb/tb_wasm_value_stack.sv
`timescale 1ns/1ps
// Bench for wasm_value_stack (DEPTH=2, 4 entries): directed vector table,
// hand-written asynchronous-reset sequences, and randomized ops checked
// against a queue-based reference model.
module tb_wasm_value_stack;

  localparam int DW    = 64;
  localparam int DEPTH = 2;
  localparam int CAPN  = 4;

  logic             clk;
  logic             reset;
  logic             valid;
  logic [2:0]       op;
  logic [DW-1:0]    data_in;
  logic [DW-1:0]    top;
  logic [DW-1:0]    next;
  logic             empty;
  logic             full;
  logic [DEPTH:0]   count;
  logic [3:0]       trap;

  int n_tests = 0;
  int n_fail  = 0;

  wasm_value_stack #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid   (valid),
    .op      (op),
    .data_in (data_in),
    .top     (top),
    .next    (next),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .trap    (trap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] m_q[$];
  int            m_trap;

  task automatic model_reset();
    m_q.delete();
    m_trap = 0;
  endtask

  task automatic model_op(input logic v, input logic [2:0] o, input logic [DW-1:0] d);
    logic [DW-1:0] t;
    int n;
    if (!v || m_trap != 0) return;
    n = m_q.size();
    case (o)
      3'd1: if (n == CAPN) m_trap = 1; else m_q.push_back(d);
      3'd2: if (n == 0) m_trap = 2; else t = m_q.pop_back();
      3'd3: if (n == 0) m_trap = 2; else m_q[n-1] = d;
      3'd4: if (n < 2) m_trap = 2; else begin t = m_q.pop_back(); m_q[n-2] = d; end
      3'd5: if (n == 0) m_trap = 2; else if (n == CAPN) m_trap = 1; else m_q.push_back(m_q[n-1]);
      3'd6: if (n < 2) m_trap = 2; else begin t = m_q[n-1]; m_q[n-1] = m_q[n-2]; m_q[n-2] = t; end
      3'd7: m_q.delete();
      default: ;
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic check_exp(input string tag, input int ec, input logic [DW-1:0] et,
                           input logic [DW-1:0] en, input int etr);
    logic ee, ef;
    ee = (ec == 0);
    ef = (ec == CAPN);
    n_tests++;
    if (count !== (DEPTH+1)'(ec) || top !== et || next !== en ||
        empty !== ee || full !== ef || trap !== 4'(etr)) begin
      n_fail++;
      $display("FAIL %s: got count=%0d top=%h next=%h empty=%b full=%b trap=%0d | want count=%0d top=%h next=%h empty=%b full=%b trap=%0d",
               tag, count, top, next, empty, full, trap, ec, et, en, ee, ef, etr);
    end else begin
      $display("[TB] %s count=%0d top=%h next=%h trap=%0d ok", tag, count, top, next, trap);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    logic [DW-1:0] et, en;
    n  = m_q.size();
    et = (n >= 1) ? m_q[n-1] : '0;
    en = (n >= 2) ? m_q[n-2] : '0;
    check_exp(tag, n, et, en, m_trap);
  endtask

  // ---------------- drivers ----------------
  task automatic do_op(input logic v, input logic [2:0] o, input logic [DW-1:0] d);
    @(negedge clk);
    valid   = v;
    op      = o;
    data_in = d;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            rst;
    bit            v;
    logic [2:0]    o;
    logic [DW-1:0] d;
    int            ec;
    logic [DW-1:0] et;
    logic [DW-1:0] en;
    int            etr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input bit v, input logic [2:0] o, input logic [DW-1:0] d,
                     input int ec, input logic [DW-1:0] et, input logic [DW-1:0] en, input int etr);
    vec_t x;
    x.rst = rst; x.v = v; x.o = o; x.d = d;
    x.ec = ec; x.et = et; x.en = en; x.etr = etr;
    vecs.push_back(x);
  endtask

  task automatic add_rst();
    add(1'b1, 1'b0, 3'd0, '0, 0, '0, '0, 0);
  endtask

  initial begin
    string tag;
    reset   = 1'b0;
    valid   = 1'b0;
    op      = 3'd0;
    data_in = '0;
    model_reset();

    // eq-collapse
    add_rst();
    add(0, 1, 3'd1, 64'd5, 1, 64'd5, 64'd0, 0);
    add(0, 1, 3'd1, 64'd5, 2, 64'd5, 64'd5, 0);
    add(0, 1, 3'd4, 64'd1, 1, 64'd1, 64'd0, 0);
    // swap / pop / dup
    add_rst();
    add(0, 1, 3'd1, 64'd7, 1, 64'd7, 64'd0, 0);
    add(0, 1, 3'd1, 64'd3, 2, 64'd3, 64'd7, 0);
    add(0, 1, 3'd6, 64'd0, 2, 64'd7, 64'd3, 0);
    add(0, 1, 3'd2, 64'd0, 1, 64'd3, 64'd0, 0);
    add(0, 1, 3'd5, 64'd0, 2, 64'd3, 64'd3, 0);
    // fill, overflow, frozen afterwards (CLEAR included)
    add_rst();
    add(0, 1, 3'd1, 64'd1, 1, 64'd1, 64'd0, 0);
    add(0, 1, 3'd1, 64'd2, 2, 64'd2, 64'd1, 0);
    add(0, 1, 3'd1, 64'd3, 3, 64'd3, 64'd2, 0);
    add(0, 1, 3'd1, 64'd4, 4, 64'd4, 64'd3, 0);
    add(0, 1, 3'd1, 64'd9, 4, 64'd4, 64'd3, 1);
    add(0, 1, 3'd2, 64'd0, 4, 64'd4, 64'd3, 1);
    add(0, 1, 3'd7, 64'd0, 4, 64'd4, 64'd3, 1);
    // DUP on a full stack overflows
    add_rst();
    add(0, 1, 3'd1, 64'hA, 1, 64'hA, 64'd0, 0);
    add(0, 1, 3'd5, 64'd0, 2, 64'hA, 64'hA, 0);
    add(0, 1, 3'd5, 64'd0, 3, 64'hA, 64'hA, 0);
    add(0, 1, 3'd5, 64'd0, 4, 64'hA, 64'hA, 0);
    add(0, 1, 3'd5, 64'd0, 4, 64'hA, 64'hA, 1);
    // underflows
    add_rst();
    add(0, 1, 3'd2, 64'd0, 0, 64'd0, 64'd0, 2);
    add_rst();
    add(0, 1, 3'd1, 64'd6, 1, 64'd6, 64'd0, 0);
    add(0, 1, 3'd4, 64'd8, 1, 64'd6, 64'd0, 2);
    add_rst();
    add(0, 1, 3'd1, 64'd6, 1, 64'd6, 64'd0, 0);
    add(0, 1, 3'd6, 64'd0, 1, 64'd6, 64'd0, 2);
    add_rst();
    add(0, 1, 3'd3, 64'd1, 0, 64'd0, 64'd0, 2);
    add_rst();
    add(0, 1, 3'd5, 64'd0, 0, 64'd0, 64'd0, 2);
    // replace, valid=0 ignored, clear
    add_rst();
    add(0, 1, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
    add(0, 1, 3'd3, 64'h2A, 1, 64'h2A, 64'd0, 0);
    add(0, 0, 3'd1, 64'h77, 1, 64'h2A, 64'd0, 0);
    add(0, 0, 3'd7, 64'h0, 1, 64'h2A, 64'd0, 0);
    add(0, 0, 3'd2, 64'h0, 1, 64'h2A, 64'd0, 0);
    add(0, 1, 3'd0, 64'h55, 1, 64'h2A, 64'd0, 0);
    add(0, 1, 3'd7, 64'h0, 0, 64'd0, 64'd0, 0);
    add(0, 0, 3'd2, 64'h0, 0, 64'd0, 64'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      tag = $sformatf("vec%0d %s v=%0b op=%0d d=%h", i, vecs[i].rst ? "rst" : "op ",
                      vecs[i].v, vecs[i].o, vecs[i].d);
      if (vecs[i].rst) do_reset();
      else             do_op(vecs[i].v, vecs[i].o, vecs[i].d);
      check_exp(tag, vecs[i].ec, vecs[i].et, vecs[i].en, vecs[i].etr);
    end

    // ---------------- asynchronous reset during a PUSH ----------------
    do_reset();
    do_op(1'b1, 3'd1, 64'd11);
    do_op(1'b1, 3'd1, 64'd22);
    check_exp("async pre", 2, 64'd22, 64'd11, 0);
    @(negedge clk);
    valid = 1'b1; op = 3'd1; data_in = 64'd33;
    #2;
    reset = 1'b0;
    #1;
    check_exp("async immediate", 0, 64'd0, 64'd0, 0);
    @(posedge clk);
    #1;
    check_exp("async held over edge", 0, 64'd0, 64'd0, 0);
    valid = 1'b0;
    #1;
    reset = 1'b1;
    do_op(1'b1, 3'd1, 64'd44);
    check_exp("async push after release", 1, 64'd44, 64'd0, 0);

    // asynchronous reset clears a latched trap without a clock edge
    do_op(1'b1, 3'd2, 64'd0);
    do_op(1'b1, 3'd2, 64'd0);
    check_exp("trap before async", 0, 64'd0, 64'd0, 2);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_exp("trap async cleared", 0, 64'd0, 64'd0, 0);
    #1;
    reset = 1'b1;
    model_reset();

    // ---------------- randomized vs. model ----------------
    for (int i = 0; i < 400; i++) begin
      logic v;
      logic [2:0] o;
      logic [DW-1:0] d;
      int r;
      if ($urandom_range(0, 24) == 0 || (m_trap != 0 && $urandom_range(0, 2) == 0)) begin
        do_reset();
        check_model($sformatf("rnd%0d rst", i));
      end
      r = $urandom_range(0, 9);
      if (r <= 2)      o = 3'd1;
      else if (r == 3) o = 3'd2;
      else             o = 3'($urandom_range(0, 7));
      v = ($urandom_range(0, 7) != 0);
      d = {$urandom, $urandom};
      model_op(v, o, d);
      do_op(v, o, d);
      check_model($sformatf("rnd%0d v=%0b op=%0d d=%h", i, v, o, d));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
